// File: rtl/frac_clken_gen.sv
// frac_clken_gen: multi-channel fractional clock-enable generator.
// Each channel runs a phase accumulator and emits an enable pulse on every carry.
//
// Ports:
//   refclk    - sole clock; all logic runs on its rising edge
//   rst       - synchronous active-high reset
//   cfg_valid - retune request
//   cfg_ready - request can be accepted (low only in LOAD)
//   cfg_ch    - target channel; codes >= NUM_CH select no channel
//   cfg_inc   - new phase increment
//   cfg_phase - accumulator preload value
//   clk_en    - per-channel single-cycle enable (registered carry)
//   clk_out   - per-channel strobe (accumulator MSB)
//   locked    - high when no retune is settling
module frac_clken_gen #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 32,
  parameter int LOCK_CYCLES = 1024,
  parameter int unsigned RESET_INC = 32'h4000_0000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  logic             hs;
  logic [CH_W-1:0]  cap_ch;
  logic [ACC_W-1:0] cap_inc;
  logic [ACC_W-1:0] cap_phase;

  assign hs       = cfg_valid & cfg_ready;
  assign cnt_done = (cnt == CNT_W'(LOCK_CYCLES - 1));

  // State register, settle counter and config capture.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ST_SETTLE;
      cnt       <= '0;
      cap_ch    <= '0;
      cap_inc   <= '0;
      cap_phase <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        cap_ch    <= cfg_ch;
        cap_inc   <= cfg_inc;
        cap_phase <= cfg_phase;
      end
      // A handshake during SETTLE routes through LOAD, which zeroes cnt,
      // so the settle window always restarts from the latest retune.
      if (state == ST_LOAD) begin
        cnt <= '0;
      end else if (state == ST_SETTLE && !hs && !cnt_done) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD: begin
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (hs) begin
          state_nxt = ST_LOAD;
        end else if (cnt_done) begin
          state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (hs) begin
          state_nxt = ST_LOAD;
        end
      end
      default: begin
        state_nxt = ST_SETTLE;
      end
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    cfg_ready = (state != ST_LOAD);
    locked    = (state == ST_LOCKED);
  end

  // Per-channel accumulators. A channel is written only when the captured
  // code equals its index, so out-of-range codes leave every channel alone.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic             en_q;
    logic             ld;

    assign sum = {1'b0, acc} + {1'b0, inc};
    assign ld  = (state == ST_LOAD) && (cap_ch == CH_W'(i));

    always_ff @(posedge refclk) begin
      if (rst) begin
        acc  <= '0;
        inc  <= ACC_W'(RESET_INC);
        en_q <= 1'b0;
      end else if (ld) begin
        acc  <= cap_phase;
        inc  <= cap_inc;
        en_q <= 1'b0;
      end else begin
        acc  <= sum[ACC_W-1:0];
        en_q <= sum[ACC_W];
      end
    end

    assign clk_en[i]  = en_q;
    assign clk_out[i] = acc[ACC_W-1];
  end

endmodule

// File: tb/tb_frac_clken_gen.sv
// tb_frac_clken_gen: randomized and directed checks of frac_clken_gen
// against an arithmetic reference model of the accumulators and lock timing.
module tb_frac_clken_gen;

  localparam int NCH  = 3;
  localparam int AW   = 8;
  localparam int LCK  = 4;
  localparam int RINC = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic [7:0] cfg_phase = '0;
  logic [2:0] clk_en;
  logic [2:0] clk_out;
  logic       locked;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: integer accumulators, timestamp-based lock.
  int         m_acc[NCH];
  int         m_inc[NCH];
  logic [2:0] m_en = '0;
  int         edge_n = 0;
  int         lock_at = 0;
  bit         pend = 0;
  int         p_ch, p_inc, p_ph;

  always #5 clk = ~clk;

  frac_clken_gen #(
    .NUM_CH(NCH),
    .ACC_W(AW),
    .LOCK_CYCLES(LCK),
    .RESET_INC(RINC)
  ) dut (
    .refclk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc),
    .cfg_phase(cfg_phase),
    .clk_en(clk_en),
    .clk_out(clk_out),
    .locked(locked)
  );

  function automatic logic [7:0] mvec();
    logic [2:0] o;
    o = '0;
    for (int i = 0; i < NCH; i++) o[i] = (m_acc[i] >= 128);
    return {m_en, o, (!pend && edge_n >= lock_at), !pend};
  endfunction

  function automatic logic [7:0] dvec();
    return {clk_en, clk_out, locked, cfg_ready};
  endfunction

  // Advance one clock edge and update the model from the sampled inputs.
  task automatic step();
    int s;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0;
        m_inc[i] = RINC;
      end
      m_en    = '0;
      pend    = 0;
      lock_at = edge_n + LCK;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        s        = m_acc[i] + m_inc[i];
        m_en[i]  = (s >= 256);
        m_acc[i] = s % 256;
      end
      if (pend) begin
        pend = 0;
        if (p_ch < NCH) begin
          m_acc[p_ch] = p_ph;
          m_inc[p_ch] = p_inc;
          m_en[p_ch]  = 1'b0;
        end
      end else if (cfg_valid) begin
        pend    = 1;
        p_ch    = int'(cfg_ch);
        p_inc   = int'(cfg_inc);
        p_ph    = int'(cfg_phase);
        lock_at = edge_n + 1 + LCK;
      end
    end
    #1;
  endtask

  task automatic do_cfg(input int ch, input int inc, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_inc   = 8'(inc);
    cfg_phase = 8'(ph);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    int pulses[NCH];
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if (dvec() !== 8'b000_000_0_1) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", dvec(), 8'b000_000_0_1);
    end
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) pulses[i] = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL reset_run k=%0d: got %b expected %b", k, dvec(), mvec());
      end
      if (k == 3 || k == 4) begin
        n_chk++;
        if (locked !== (k == 4)) begin
          n_fail++;
          $display("FAIL reset_lock k=%0d: got %b expected %b", k, locked, k == 4);
        end
      end
      for (int i = 0; i < NCH; i++) if (clk_en[i]) pulses[i]++;
    end
    for (int i = 0; i < NCH; i++) begin
      n_chk++;
      if (pulses[i] != 2) begin
        n_fail++;
        $display("FAIL reset_pulses ch%0d: got %0d expected 2", i, pulses[i]);
      end
    end
  endtask

  task automatic test_retune();
    int p1, p0;
    p1 = 0;
    p0 = 0;
    do_cfg(1, 96, 0);
    n_chk++;
    if ({locked, cfg_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL retune_load: got %b expected 00", {locked, cfg_ready});
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL retune k=%0d: got %b expected %b", k, dvec(), mvec());
      end
      if (k == 4 || k == 5) begin
        n_chk++;
        if (locked !== (k == 5)) begin
          n_fail++;
          $display("FAIL retune_lock k=%0d: got %b expected %b", k, locked, k == 5);
        end
      end
      if (k >= 2) begin
        if (clk_en[1]) p1++;
        if (clk_en[0]) p0++;
      end
    end
    n_chk++;
    if (p1 != 3 || p0 != 2) begin
      n_fail++;
      $display("FAIL retune_pulses: got ch1=%0d ch0=%0d expected 3 2", p1, p0);
    end
  endtask

  task automatic test_freeze();
    do_cfg(2, 0, 128);
    for (int k = 1; k <= 12; k++) begin
      step();
      n_chk++;
      if (dvec() !== mvec() || clk_out[2] !== 1'b1 || clk_en[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze k=%0d: got %b expected %b", k, dvec(), mvec());
      end
    end
  endtask

  task automatic test_back_to_back();
    do_cfg(0, 20, 5);
    for (int k = 1; k <= 2; k++) begin
      step();
      n_chk++;
      if (dvec() !== mvec() || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d: got %b expected %b", k, dvec(), mvec());
      end
    end
    do_cfg(1, 50, 7);
    for (int k = 1; k <= 6; k++) begin
      step();
      n_chk++;
      if (dvec() !== mvec() || locked !== (k >= 5)) begin
        n_fail++;
        $display("FAIL b2b k=%0d: got %b expected %b", k, dvec(), mvec());
      end
    end
  endtask

  task automatic test_out_of_range();
    do_cfg(3, 10, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      n_chk++;
      if (dvec() !== mvec() || locked !== (k >= 5)) begin
        n_fail++;
        $display("FAIL oor k=%0d: got %b expected %b", k, dvec(), mvec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_cfg(1, 200, 3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (dvec() !== 8'b000_000_0_1) begin
      n_fail++;
      $display("FAIL rstmid_state: got %b expected %b", dvec(), 8'b000_000_0_1);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL rstmid k=%0d: got %b expected %b", k, dvec(), mvec());
      end
    end
    n_chk++;
    if (clk_en !== 3'b111 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_end: got en=%b lk=%b expected 111 1", clk_en, locked);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_inc   = 8'($urandom);
      cfg_phase = 8'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      step();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL random c=%0d: got %b expected %b", c, dvec(), mvec());
      end
    end
    cfg_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0;
      m_inc[i] = 0;
    end
    test_reset();
    test_retune();
    test_freeze();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_clken_gen.md
# frac_clken_gen

Multi-channel, runtime-programmable fractional clock-enable generator. It is the parametrised successor to the fixed-ratio PLL wrapper and runs entirely in the `refclk` domain. Each channel uses an ACC_W-bit phase accumulator to produce a single-cycle enable pulse and a near-50% square-wave strobe at f_ref·inc/2^ACC_W. A valid/ready config port retunes any channel at runtime, and `locked` is deasserted while any retune settles. It feeds pixel-rate, baud-rate and sample-rate enables to downstream logic without a new PLL instance per frequency.

## Interface
- NUM_CH, 2: number of independent channels (≥1).
- ACC_W, 32: accumulator and increment width (≥4).
- LOCK_CYCLES, 1024: settle cycles before `locked` reasserts (≥1).
- RESET_INC, 32'h4000_0000: increment loaded into every channel at reset, truncated to ACC_W bits.
- CH_W (localparam) = max(1, clog2(NUM_CH)).

Ports:
- refclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  block can accept config.
- cfg_ch  in  CH_W  target channel.
- cfg_inc  in  ACC_W  new increment.
- cfg_phase  in  ACC_W  accumulator preload value.
- clk_en  out  NUM_CH  per-channel one-cycle enable pulse, registered.
- clk_out  out  NUM_CH  per-channel strobe, equal to the accumulator MSB.
- locked  out  1  high when no reconfiguration is settling.

## Operation
- Per channel i: registers acc[i] and inc[i]. Each edge computes {carry, acc[i]} ← acc[i] + inc[i] (ACC_W+1-bit sum, wraps mod 2^ACC_W).
- clk_en[i] ← carry. clk_out[i] = acc[i][ACC_W-1].
- inc = 0: channel frozen; acc holds, clk_en stays 0, clk_out is constant.
- inc ≥ 2^(ACC_W-1): clk_en remains correct (it may pulse on consecutive cycles), but clk_out is undefined as a square wave. This is legal; it is not flagged.
- FSM states: LOAD, SETTLE, LOCKED.
  - SETTLE: cnt increments each edge. When cnt == LOCK_CYCLES-1 the FSM moves to LOCKED.
  - LOCKED: idle.
  - Handshake (cfg_valid & cfg_ready) from SETTLE or LOCKED: capture cfg_ch, cfg_inc and cfg_phase, then go to LOAD.
  - LOAD: if captured ch < NUM_CH, write inc[ch] ← cfg_inc and acc[ch] ← cfg_phase, and force clk_en[ch] ← 0 on that edge. Then go to SETTLE with cnt ← 0.
  - Out-of-range ch: no channel is written, but LOAD → SETTLE still occurs and `locked` still drops.
- cfg_ready = (state != LOAD). locked = (state == LOCKED).
- Accepting a config while in SETTLE restarts the settle count from 0.
- Channels that are not being loaded free-run through LOAD and SETTLE without glitching. The loaded channel accumulates with its old inc during the LOAD cycle.

## Timing
- Reset (rst high at an edge):
  - acc = 0 and inc = RESET_INC for all channels.
  - clk_en = 0, clk_out = 0.
  - state = SETTLE, cnt = 0, locked = 0, cfg_ready = 1.
  - rst dominates any concurrent handshake.
- After reset deasserts: locked = 1 after exactly LOCK_CYCLES edges.
- Handshake at edge E0:
  - After E0: LOAD, cfg_ready = 0, locked = 0.
  - After E0+1: new inc/acc visible, SETTLE.
  - After E0+1+LOCK_CYCLES: locked = 1.
- New frequency: the first carry using the new inc appears on clk_en at E0+2 at the earliest.
- Reset mid-LOAD or mid-SETTLE returns everything to reset values; the pending config is discarded.

## Test plan
Bench parameters: NUM_CH=3, ACC_W=8, LOCK_CYCLES=4, RESET_INC=64.
- Reset, release -> locked rises 4 edges after release. Every channel shows clk_en pulsing once per 4 cycles and clk_out pattern 0,0,1,1 repeating.
- Config ch1, inc=96, phase=0 -> locked low at E0+1, high at E0+5. ch1 acc runs 0,96,192,32,128,224,64,160,0; clk_en fires at 32, 64 and 0 (3 pulses per 8 cycles). ch0 and ch2 are unperturbed.
- Config ch2, inc=0, phase=128 -> clk_out[2] stays 1 and clk_en[2] stays 0 indefinitely.
- Config ch0 at E0, then a second config at E0+3 (during SETTLE) -> locked stays low until E0+3+5. Both writes take effect.
- Config cfg_ch=3 (out of range), inc=10 -> no channel changes. locked still drops for 5 edges, then reasserts.
- Assert rst at E0+2 mid-SETTLE -> all outputs return to reset values at the next edge. Channel inc reverts to 64, and locked reasserts 4 edges after rst deasserts.
